// File: rtl/mc_riscv_ctrl_hs.sv
// Multicycle RV64I control unit with req/ready memory handshakes.
// Drives datapath load strobes and mux selects; stops in HALT on illegal opcode or memory timeout.
module mc_riscv_ctrl_hs #(
  parameter int unsigned WAIT_W          = 8,
  parameter bit          TIMEOUT_EN      = 1'b1,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] IR31_0,
  input  logic        IGUAL,
  input  logic        MAIOR,
  input  logic        MENOR,
  output logic        imem_req,
  input  logic        imem_ready,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  output logic        IR_WIRE,
  output logic        LOAD_A,
  output logic        LOAD_B,
  output logic        LOAD_ALU_OUT,
  output logic        LOAD_MDR,
  output logic        BANCO_WIRE,
  output logic        MUX_MR_WIRE,
  output logic        PC_WRITE,
  output logic        PC_SRC,
  output logic [1:0]  ALU_SRCA,
  output logic [2:0]  ALU_SRCB,
  output logic [2:0]  ALU_SELECTOR,
  output logic [4:0]  SAIDA_ESTADO,
  output logic        halt,
  output logic [1:0]  err_code
);

  typedef enum logic [4:0] {
    S_RST      = 5'd0,
    S_FETCH    = 5'd1,
    S_DECODE   = 5'd2,
    S_EXEC_R   = 5'd3,
    S_EXEC_I   = 5'd4,
    S_WB_ALU   = 5'd5,
    S_MEM_ADDR = 5'd6,
    S_MEM_RD   = 5'd7,
    S_WB_MEM   = 5'd8,
    S_MEM_WR   = 5'd9,
    S_BRANCH   = 5'd10,
    S_LUI      = 5'd11,
    S_J1       = 5'd12,
    S_J2       = 5'd13,
    S_HALT     = 5'd31
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LD     = 7'b0000011;
  localparam logic [6:0] OP_SD     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b110;
  localparam logic [2:0] ALU_CMP  = 3'b111;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  localparam logic [WAIT_W-1:0] WAIT_MAX  = '1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_MAX - WAIT_W'(1);

  state_t            state, state_nxt;
  logic [1:0]        err_q, err_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              slt_lt;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b30;
  logic       is_slt;
  logic [2:0] r_alu_op;
  logic       branch_take;
  logic       stall;
  logic       timeout_hit;
  logic       unused_ir;

  assign opcode     = IR31_0[6:0];
  assign funct3     = IR31_0[14:12];
  assign funct7_b30 = IR31_0[30];
  assign is_slt     = (opcode == OP_R) && (funct3 == 3'b010);
  assign unused_ir  = ^{IR31_0[31], IR31_0[29:15], IR31_0[11:7]};

  always_comb begin
    unique case ({funct7_b30, funct3})
      4'b1_000: r_alu_op = ALU_SUB;
      4'b0_111: r_alu_op = ALU_AND;
      4'b0_100: r_alu_op = ALU_XOR;
      4'b0_010: r_alu_op = ALU_CMP;
      default:  r_alu_op = ALU_ADD;
    endcase
  end

  always_comb begin
    unique case (funct3)
      3'b000:  branch_take = IGUAL;
      3'b001:  branch_take = !IGUAL;
      3'b100:  branch_take = MENOR;
      3'b101:  branch_take = MAIOR | IGUAL;
      default: branch_take = 1'b0;
    endcase
  end

  // Requests are asserted exactly in these states, so a stall is derived from
  // state alone rather than from the request outputs (avoids a comb loop).
  assign stall = ((state == S_FETCH) && !imem_ready) ||
                 (((state == S_MEM_RD) || (state == S_MEM_WR)) && !dmem_ready);
  assign timeout_hit = TIMEOUT_EN && stall && (wait_cnt == WAIT_LAST);

  // NOTE: reset is synchronous, so it sits inside the clocked branch and
  // RESET is not in the sensitivity list.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= S_RST;
      err_q    <= ERR_NONE;
      wait_cnt <= '0;
      slt_lt   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, independent of statement order.
      state <= state_nxt;
      err_q <= err_nxt;
      if (state == S_EXEC_R) slt_lt <= MENOR;
      if (!stall)                   wait_cnt <= '0;
      else if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would infer a latch.
  always_comb begin
    state_nxt    = state;
    err_nxt      = err_q;
    imem_req     = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    IR_WIRE      = 1'b0;
    LOAD_A       = 1'b0;
    LOAD_B       = 1'b0;
    LOAD_ALU_OUT = 1'b0;
    LOAD_MDR     = 1'b0;
    BANCO_WIRE   = 1'b0;
    MUX_MR_WIRE  = 1'b0;
    PC_WRITE     = 1'b0;
    PC_SRC       = 1'b0;
    ALU_SRCA     = 2'd0;
    ALU_SRCB     = 3'd0;
    ALU_SELECTOR = ALU_PASS;
    halt         = 1'b0;

    unique case (state)
      S_RST: state_nxt = S_FETCH;

      S_FETCH: begin
        imem_req     = 1'b1;
        ALU_SRCA     = 2'd0;
        ALU_SRCB     = 3'd1;
        ALU_SELECTOR = ALU_ADD;
        if (imem_ready) begin
          IR_WIRE   = 1'b1;
          PC_WRITE  = 1'b1;
          state_nxt = S_DECODE;
        end else if (timeout_hit) begin
          state_nxt = S_HALT;
          err_nxt   = ERR_TIMEOUT;
        end
      end

      S_DECODE: begin
        LOAD_A       = 1'b1;
        LOAD_B       = 1'b1;
        LOAD_ALU_OUT = 1'b1;
        ALU_SRCA     = 2'd0;
        ALU_SRCB     = 3'd3;
        ALU_SELECTOR = ALU_ADD;
        unique case (opcode)
          OP_R:          state_nxt = S_EXEC_R;
          OP_I:          state_nxt = S_EXEC_I;
          OP_LD, OP_SD:  state_nxt = S_MEM_ADDR;
          OP_BRANCH:     state_nxt = S_BRANCH;
          OP_LUI:        state_nxt = S_LUI;
          OP_JAL:        state_nxt = S_J1;
          default: begin
            if (HALT_ON_ILLEGAL) begin
              state_nxt = S_HALT;
              err_nxt   = ERR_ILLEGAL;
            end else begin
              state_nxt = S_FETCH;
            end
          end
        endcase
      end

      S_EXEC_R: begin
        ALU_SRCA     = 2'd1;
        ALU_SRCB     = 3'd0;
        ALU_SELECTOR = r_alu_op;
        LOAD_ALU_OUT = 1'b1;
        state_nxt    = S_WB_ALU;
      end

      S_EXEC_I: begin
        ALU_SRCA     = 2'd1;
        ALU_SRCB     = 3'd2;
        ALU_SELECTOR = ALU_ADD;
        LOAD_ALU_OUT = 1'b1;
        state_nxt    = S_WB_ALU;
      end

      S_WB_ALU: begin
        BANCO_WIRE = 1'b1;
        // slt writes the flag captured in EXEC_R: zero source with its LSB set to the flag.
        if (is_slt) begin
          ALU_SRCA     = {1'b1, slt_lt};
          ALU_SRCB     = 3'd4;
          ALU_SELECTOR = ALU_PASS;
        end
        state_nxt = S_FETCH;
      end

      S_MEM_ADDR: begin
        ALU_SRCA     = 2'd1;
        ALU_SRCB     = 3'd2;
        ALU_SELECTOR = ALU_ADD;
        LOAD_ALU_OUT = 1'b1;
        state_nxt    = (opcode == OP_LD) ? S_MEM_RD : S_MEM_WR;
      end

      S_MEM_RD: begin
        dmem_req = 1'b1;
        if (dmem_ready) begin
          LOAD_MDR  = 1'b1;
          state_nxt = S_WB_MEM;
        end else if (timeout_hit) begin
          state_nxt = S_HALT;
          err_nxt   = ERR_TIMEOUT;
        end
      end

      S_WB_MEM: begin
        MUX_MR_WIRE = 1'b1;
        BANCO_WIRE  = 1'b1;
        state_nxt   = S_FETCH;
      end

      S_MEM_WR: begin
        dmem_req = 1'b1;
        dmem_we  = 1'b1;
        if (dmem_ready) begin
          state_nxt = S_FETCH;
        end else if (timeout_hit) begin
          state_nxt = S_HALT;
          err_nxt   = ERR_TIMEOUT;
        end
      end

      S_BRANCH: begin
        ALU_SRCA     = 2'd1;
        ALU_SRCB     = 3'd0;
        ALU_SELECTOR = ALU_CMP;
        if (branch_take) begin
          PC_WRITE = 1'b1;
          PC_SRC   = 1'b1;
        end
        state_nxt = S_FETCH;
      end

      S_LUI: begin
        ALU_SRCA     = 2'd2;
        ALU_SRCB     = 3'd2;
        ALU_SELECTOR = ALU_ADD;
        BANCO_WIRE   = 1'b1;
        state_nxt    = S_FETCH;
      end

      S_J1: begin
        ALU_SRCA     = 2'd0;
        ALU_SRCB     = 3'd4;
        ALU_SELECTOR = ALU_ADD;
        BANCO_WIRE   = 1'b1;
        state_nxt    = S_J2;
      end

      S_J2: begin
        PC_WRITE  = 1'b1;
        PC_SRC    = 1'b1;
        state_nxt = S_FETCH;
      end

      S_HALT: halt = 1'b1;

      default: state_nxt = S_RST;
    endcase
  end

  assign SAIDA_ESTADO = state;
  assign err_code     = err_q;

endmodule

// File: tb/tb_mc_riscv_ctrl_hs.sv
// Scoreboard bench for mc_riscv_ctrl_hs: stimulus queues hand-computed output
// vectors per cycle, a monitor compares them on the falling edge.
module tb_mc_riscv_ctrl_hs;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] IR31_0;
  logic        IGUAL, MAIOR, MENOR;
  logic        imem_ready, dmem_ready;

  always #5 CLK = ~CLK;

  // Outputs of the default-parameter instance (a) and the WAIT_W=3 instance (b).
  logic       imem_req_a, dmem_req_a, dmem_we_a, ir_wire_a, load_a_a, load_b_a;
  logic       load_alu_out_a, load_mdr_a, banco_a, mux_mr_a, pc_write_a, pc_src_a;
  logic [1:0] srca_a, err_a;
  logic [2:0] srcb_a, sel_a;
  logic [4:0] st_a;
  logic       halt_a;

  logic       imem_req_b, dmem_req_b, dmem_we_b, ir_wire_b, load_a_b, load_b_b;
  logic       load_alu_out_b, load_mdr_b, banco_b, mux_mr_b, pc_write_b, pc_src_b;
  logic [1:0] srca_b, err_b;
  logic [2:0] srcb_b, sel_b;
  logic [4:0] st_b;
  logic       halt_b;

  mc_riscv_ctrl_hs dut_a (
    .CLK(CLK), .RESET(RESET), .IR31_0(IR31_0),
    .IGUAL(IGUAL), .MAIOR(MAIOR), .MENOR(MENOR),
    .imem_req(imem_req_a), .imem_ready(imem_ready),
    .dmem_req(dmem_req_a), .dmem_we(dmem_we_a), .dmem_ready(dmem_ready),
    .IR_WIRE(ir_wire_a), .LOAD_A(load_a_a), .LOAD_B(load_b_a),
    .LOAD_ALU_OUT(load_alu_out_a), .LOAD_MDR(load_mdr_a),
    .BANCO_WIRE(banco_a), .MUX_MR_WIRE(mux_mr_a),
    .PC_WRITE(pc_write_a), .PC_SRC(pc_src_a),
    .ALU_SRCA(srca_a), .ALU_SRCB(srcb_a), .ALU_SELECTOR(sel_a),
    .SAIDA_ESTADO(st_a), .halt(halt_a), .err_code(err_a)
  );

  mc_riscv_ctrl_hs #(.WAIT_W(3)) dut_b (
    .CLK(CLK), .RESET(RESET), .IR31_0(IR31_0),
    .IGUAL(IGUAL), .MAIOR(MAIOR), .MENOR(MENOR),
    .imem_req(imem_req_b), .imem_ready(imem_ready),
    .dmem_req(dmem_req_b), .dmem_we(dmem_we_b), .dmem_ready(dmem_ready),
    .IR_WIRE(ir_wire_b), .LOAD_A(load_a_b), .LOAD_B(load_b_b),
    .LOAD_ALU_OUT(load_alu_out_b), .LOAD_MDR(load_mdr_b),
    .BANCO_WIRE(banco_b), .MUX_MR_WIRE(mux_mr_b),
    .PC_WRITE(pc_write_b), .PC_SRC(pc_src_b),
    .ALU_SRCA(srca_b), .ALU_SRCB(srcb_b), .ALU_SELECTOR(sel_b),
    .SAIDA_ESTADO(st_b), .halt(halt_b), .err_code(err_b)
  );

  // Vector layout: {strobes[11:0], srca[1:0], srcb[2:0], sel[2:0], state[4:0], halt, err[1:0]}
  // strobes = {imem_req, dmem_req, dmem_we, IR_WIRE, LOAD_A, LOAD_B,
  //            LOAD_ALU_OUT, LOAD_MDR, BANCO_WIRE, MUX_MR_WIRE, PC_WRITE, PC_SRC}
  logic [27:0] act_a, act_b;
  assign act_a = {imem_req_a, dmem_req_a, dmem_we_a, ir_wire_a, load_a_a, load_b_a,
                  load_alu_out_a, load_mdr_a, banco_a, mux_mr_a, pc_write_a, pc_src_a,
                  srca_a, srcb_a, sel_a, st_a, halt_a, err_a};
  assign act_b = {imem_req_b, dmem_req_b, dmem_we_b, ir_wire_b, load_a_b, load_b_b,
                  load_alu_out_b, load_mdr_b, banco_b, mux_mr_b, pc_write_b, pc_src_b,
                  srca_b, srcb_b, sel_b, st_b, halt_b, err_b};

  localparam logic [11:0] S_IREQ  = 12'h800;
  localparam logic [11:0] S_DREQ  = 12'h400;
  localparam logic [11:0] S_DWE   = 12'h200;
  localparam logic [11:0] S_IR    = 12'h100;
  localparam logic [11:0] S_LA    = 12'h080;
  localparam logic [11:0] S_LB    = 12'h040;
  localparam logic [11:0] S_LAO   = 12'h020;
  localparam logic [11:0] S_LMDR  = 12'h010;
  localparam logic [11:0] S_BANCO = 12'h008;
  localparam logic [11:0] S_MUXMR = 12'h004;
  localparam logic [11:0] S_PCW   = 12'h002;
  localparam logic [11:0] S_PCSRC = 12'h001;
  localparam logic [11:0] S_NONE  = 12'h000;

  localparam logic [27:0] E_RST       = {S_NONE,                 2'd0, 3'd0, 3'd0, 5'd0,  1'b0, 2'd0};
  localparam logic [27:0] E_FETCH_W   = {S_IREQ,                 2'd0, 3'd1, 3'd1, 5'd1,  1'b0, 2'd0};
  localparam logic [27:0] E_FETCH_R   = {S_IREQ | S_IR | S_PCW,  2'd0, 3'd1, 3'd1, 5'd1,  1'b0, 2'd0};
  localparam logic [27:0] E_DECODE    = {S_LA | S_LB | S_LAO,    2'd0, 3'd3, 3'd1, 5'd2,  1'b0, 2'd0};
  localparam logic [27:0] E_EXEC_ADD  = {S_LAO,                  2'd1, 3'd0, 3'd1, 5'd3,  1'b0, 2'd0};
  localparam logic [27:0] E_EXEC_SUB  = {S_LAO,                  2'd1, 3'd0, 3'd2, 5'd3,  1'b0, 2'd0};
  localparam logic [27:0] E_EXEC_XOR  = {S_LAO,                  2'd1, 3'd0, 3'd6, 5'd3,  1'b0, 2'd0};
  localparam logic [27:0] E_EXEC_SLT  = {S_LAO,                  2'd1, 3'd0, 3'd7, 5'd3,  1'b0, 2'd0};
  localparam logic [27:0] E_EXEC_I    = {S_LAO,                  2'd1, 3'd2, 3'd1, 5'd4,  1'b0, 2'd0};
  localparam logic [27:0] E_WB        = {S_BANCO,                2'd0, 3'd0, 3'd0, 5'd5,  1'b0, 2'd0};
  localparam logic [27:0] E_WB_SLT1   = {S_BANCO,                2'd3, 3'd4, 3'd0, 5'd5,  1'b0, 2'd0};
  localparam logic [27:0] E_WB_SLT0   = {S_BANCO,                2'd2, 3'd4, 3'd0, 5'd5,  1'b0, 2'd0};
  localparam logic [27:0] E_MADDR     = {S_LAO,                  2'd1, 3'd2, 3'd1, 5'd6,  1'b0, 2'd0};
  localparam logic [27:0] E_MRD_W     = {S_DREQ,                 2'd0, 3'd0, 3'd0, 5'd7,  1'b0, 2'd0};
  localparam logic [27:0] E_MRD_R     = {S_DREQ | S_LMDR,        2'd0, 3'd0, 3'd0, 5'd7,  1'b0, 2'd0};
  localparam logic [27:0] E_WBMEM     = {S_BANCO | S_MUXMR,      2'd0, 3'd0, 3'd0, 5'd8,  1'b0, 2'd0};
  localparam logic [27:0] E_MWR       = {S_DREQ | S_DWE,         2'd0, 3'd0, 3'd0, 5'd9,  1'b0, 2'd0};
  localparam logic [27:0] E_BR_T      = {S_PCW | S_PCSRC,        2'd1, 3'd0, 3'd7, 5'd10, 1'b0, 2'd0};
  localparam logic [27:0] E_BR_N      = {S_NONE,                 2'd1, 3'd0, 3'd7, 5'd10, 1'b0, 2'd0};
  localparam logic [27:0] E_LUI       = {S_BANCO,                2'd2, 3'd2, 3'd1, 5'd11, 1'b0, 2'd0};
  localparam logic [27:0] E_J1        = {S_BANCO,                2'd0, 3'd4, 3'd1, 5'd12, 1'b0, 2'd0};
  localparam logic [27:0] E_J2        = {S_PCW | S_PCSRC,        2'd0, 3'd0, 3'd0, 5'd13, 1'b0, 2'd0};
  localparam logic [27:0] E_HALT_ILL  = {S_NONE,                 2'd0, 3'd0, 3'd0, 5'd31, 1'b1, 2'd1};
  localparam logic [27:0] E_HALT_TO   = {S_NONE,                 2'd0, 3'd0, 3'd0, 5'd31, 1'b1, 2'd2};

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_XOR  = 32'h0020C1B3;
  localparam logic [31:0] I_SLT  = 32'h0020A1B3;
  localparam logic [31:0] I_ADDI = 32'h00500093;
  localparam logic [31:0] I_LD   = 32'h0080B283;
  localparam logic [31:0] I_SD   = 32'h0050B423;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_BNE  = 32'h00209463;
  localparam logic [31:0] I_BGE  = 32'h0020D463;
  localparam logic [31:0] I_LUI  = 32'h123452B7;
  localparam logic [31:0] I_JAL  = 32'h010000EF;
  localparam logic [31:0] I_ILL  = 32'h0000007F;

  typedef struct {
    string       nm;
    bit          on_b;
    logic [27:0] v;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string nm, input logic [27:0] act, input logic [27:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check(e.nm, e.on_b ? act_b : act_a, e.v);
      end
    end
  end

  task automatic expect_v(input string nm, input bit on_b, input logic [27:0] ev);
    exp_t e;
    e.nm   = nm;
    e.on_b = on_b;
    e.v    = ev;
    sb_q.push_back(e);
  endtask

  // flg = {IGUAL, MAIOR, MENOR}
  task automatic cyc(input string nm, input logic rst, input logic ir_rdy, input logic dm_rdy,
                     input logic [2:0] flg, input logic [27:0] ev, input bit on_b);
    RESET      = rst;
    imem_ready = ir_rdy;
    dmem_ready = dm_rdy;
    {IGUAL, MAIOR, MENOR} = flg;
    expect_v(nm, on_b, ev);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RESET = 1'b1; IR31_0 = 32'h0; IGUAL = 1'b0; MAIOR = 1'b0; MENOR = 1'b0;
    imem_ready = 1'b1; dmem_ready = 1'b0;
    @(posedge CLK);
    #1;

    cyc("rst0",      1, 1, 0, 3'b000, E_RST, 0);
    cyc("rst1",      1, 1, 0, 3'b000, E_RST, 0);
    cyc("rst_rel",   0, 1, 0, 3'b000, E_RST, 0);

    IR31_0 = I_ADD;
    cyc("add_fetch", 0, 1, 0, 3'b000, E_FETCH_R, 0);
    cyc("add_dec",   0, 1, 1, 3'b000, E_DECODE, 0);
    cyc("add_exec",  0, 1, 1, 3'b000, E_EXEC_ADD, 0);
    cyc("add_wb",    0, 1, 1, 3'b000, E_WB, 0);

    IR31_0 = I_SUB;
    cyc("sub_fetch", 0, 1, 0, 3'b000, E_FETCH_R, 0);
    cyc("sub_dec",   0, 0, 0, 3'b000, E_DECODE, 0);
    cyc("sub_exec",  0, 0, 0, 3'b000, E_EXEC_SUB, 0);
    cyc("sub_wb",    0, 0, 0, 3'b000, E_WB, 0);

    IR31_0 = I_XOR;
    cyc("xor_fetch", 0, 1, 0, 3'b000, E_FETCH_R, 0);
    cyc("xor_dec",   0, 0, 0, 3'b000, E_DECODE, 0);
    cyc("xor_exec",  0, 0, 0, 3'b000, E_EXEC_XOR, 0);
    cyc("xor_wb",    0, 0, 0, 3'b000, E_WB, 0);

    IR31_0 = I_SLT;
    cyc("slt1_fetch", 0, 1, 0, 3'b000, E_FETCH_R, 0);
    cyc("slt1_dec",   0, 0, 0, 3'b000, E_DECODE, 0);
    cyc("slt1_exec",  0, 0, 0, 3'b001, E_EXEC_SLT, 0);
    cyc("slt1_wb",    0, 0, 0, 3'b000, E_WB_SLT1, 0);
    cyc("slt0_fetch", 0, 1, 0, 3'b000, E_FETCH_R, 0);
    cyc("slt0_dec",   0, 0, 0, 3'b001, E_DECODE, 0);
    cyc("slt0_exec",  0, 0, 0, 3'b010, E_EXEC_SLT, 0);
    cyc("slt0_wb",    0, 0, 0, 3'b001, E_WB_SLT0, 0);

    IR31_0 = I_ADDI;
    cyc("addi_fetch", 0, 1, 0, 3'b000, E_FETCH_R, 0);
    cyc("addi_dec",   0, 0, 0, 3'b000, E_DECODE, 0);
    cyc("addi_exec",  0, 0, 0, 3'b000, E_EXEC_I, 0);
    cyc("addi_wb",    0, 0, 0, 3'b000, E_WB, 0);

    // ld with three data wait cycles: 8 cycles total
    IR31_0 = I_LD;
    cyc("ld_fetch",  0, 1, 0, 3'b000, E_FETCH_R, 0);
    cyc("ld_dec",    0, 0, 0, 3'b000, E_DECODE, 0);
    cyc("ld_addr",   0, 0, 0, 3'b000, E_MADDR, 0);
    cyc("ld_wait1",  0, 1, 0, 3'b000, E_MRD_W, 0);
    cyc("ld_wait2",  0, 1, 0, 3'b000, E_MRD_W, 0);
    cyc("ld_wait3",  0, 1, 0, 3'b000, E_MRD_W, 0);
    cyc("ld_rdy",    0, 0, 1, 3'b000, E_MRD_R, 0);
    cyc("ld_wb",     0, 0, 1, 3'b000, E_WBMEM, 0);

    // sd with one instruction wait cycle
    IR31_0 = I_SD;
    cyc("sd_fwait",  0, 0, 1, 3'b000, E_FETCH_W, 0);
    cyc("sd_fetch",  0, 1, 0, 3'b000, E_FETCH_R, 0);
    cyc("sd_dec",    0, 0, 0, 3'b000, E_DECODE, 0);
    cyc("sd_addr",   0, 0, 0, 3'b000, E_MADDR, 0);
    cyc("sd_wr",     0, 0, 1, 3'b000, E_MWR, 0);

    IR31_0 = I_BEQ;
    cyc("beqt_fetch", 0, 1, 0, 3'b000, E_FETCH_R, 0);
    cyc("beqt_dec",   0, 0, 0, 3'b000, E_DECODE, 0);
    cyc("beqt_br",    0, 0, 0, 3'b100, E_BR_T, 0);
    cyc("beqn_fetch", 0, 1, 0, 3'b100, E_FETCH_R, 0);
    cyc("beqn_dec",   0, 0, 0, 3'b100, E_DECODE, 0);
    cyc("beqn_br",    0, 0, 0, 3'b010, E_BR_N, 0);

    IR31_0 = I_BNE;
    cyc("bne_fetch",  0, 1, 0, 3'b000, E_FETCH_R, 0);
    cyc("bne_dec",    0, 0, 0, 3'b000, E_DECODE, 0);
    cyc("bne_br",     0, 0, 0, 3'b001, E_BR_T, 0);

    IR31_0 = I_BGE;
    cyc("bge_fetch",  0, 1, 0, 3'b000, E_FETCH_R, 0);
    cyc("bge_dec",    0, 0, 0, 3'b000, E_DECODE, 0);
    cyc("bge_br",     0, 0, 0, 3'b001, E_BR_N, 0);

    IR31_0 = I_LUI;
    cyc("lui_fetch",  0, 1, 0, 3'b000, E_FETCH_R, 0);
    cyc("lui_dec",    0, 0, 0, 3'b000, E_DECODE, 0);
    cyc("lui_exec",   0, 0, 0, 3'b000, E_LUI, 0);

    IR31_0 = I_JAL;
    cyc("jal_fetch",  0, 1, 0, 3'b000, E_FETCH_R, 0);
    cyc("jal_dec",    0, 0, 0, 3'b000, E_DECODE, 0);
    cyc("jal_j1",     0, 0, 0, 3'b000, E_J1, 0);
    cyc("jal_j2",     0, 0, 0, 3'b000, E_J2, 0);

    // Reset during a pending load drops dmem_req the next cycle
    IR31_0 = I_LD;
    cyc("rld_fetch",  0, 1, 0, 3'b000, E_FETCH_R, 0);
    cyc("rld_dec",    0, 0, 0, 3'b000, E_DECODE, 0);
    cyc("rld_addr",   0, 0, 0, 3'b000, E_MADDR, 0);
    cyc("rld_rst",    1, 0, 0, 3'b000, E_MRD_W, 0);
    cyc("rld_drop",   0, 1, 1, 3'b000, E_RST, 0);

    IR31_0 = I_ILL;
    cyc("ill_fetch",  0, 1, 0, 3'b000, E_FETCH_R, 0);
    cyc("ill_dec",    0, 1, 1, 3'b000, E_DECODE, 0);
    cyc("ill_halt1",  0, 1, 1, 3'b111, E_HALT_ILL, 0);
    cyc("ill_halt2",  0, 1, 1, 3'b111, E_HALT_ILL, 0);
    cyc("ill_rst",    1, 1, 1, 3'b000, E_HALT_ILL, 0);
    cyc("ill_rst_st", 0, 0, 0, 3'b000, E_RST, 0);

    // Instruction memory never answers: WAIT_W=3 instance halts after 7 request cycles
    IR31_0 = I_ADD;
    cyc("to_req1",    0, 0, 0, 3'b000, E_FETCH_W, 1);
    for (int i = 2; i <= 7; i++) begin
      cyc($sformatf("to_req%0d", i), 0, 0, 0, 3'b000, E_FETCH_W, 1);
    end
    expect_v("to_nohalt_a", 0, E_FETCH_W);
    @(negedge CLK);
    cyc("to_halt1",   0, 0, 0, 3'b000, E_HALT_TO, 1);
    cyc("to_halt2",   0, 1, 1, 3'b000, E_HALT_TO, 1);

    repeat (2) @(negedge CLK);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
